// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, 2-FF column synchronizer, press/release debounce, one-cycle key code.
// Optional build macro KEYPAD_GHOST_REJECT_EN: a multi-column chord at the scan sample is treated as no key.
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [3:0]    CODE_NONE = 4'd13;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b11_00: code = 4'd11;
         4'b11_01: code = 4'd0;
         4'b11_10: code = 4'd10;
         default:  code = CODE_NONE;
      endcase
      return code;
   endfunction

   function automatic logic [1:0] first_low(input logic [2:0] cs);
      logic [1:0] idx;
      if (!cs[0]) begin
         idx = 2'd0;
      end else if (!cs[1]) begin
         idx = 2'd1;
      end else begin
         idx = 2'd2;
      end
      return idx;
   endfunction

   function automatic logic col_is_low(input logic [2:0] cs, input logic [1:0] col);
      logic low;
      case (col)
         2'd0:    low = ~cs[0];
         2'd1:    low = ~cs[1];
         2'd2:    low = ~cs[2];
         default: low = 1'b0;
      endcase
      return low;
   endfunction

   function automatic logic [3:0] row_drive(input logic [1:0] row);
      logic [3:0] drv;
      case (row)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1110;
      endcase
      return drv;
   endfunction

`ifdef KEYPAD_GHOST_REJECT_EN
   function automatic logic multi_low(input logic [2:0] cs);
      return (~cs[0] & ~cs[1]) | (~cs[0] & ~cs[2]) | (~cs[1] & ~cs[2]);
   endfunction
`endif

   logic [2:0]    sync1_q;
   logic [2:0]    cs_q;
   state_t        state_q, state_d;
   logic [1:0]    row_q, row_d;
   logic [1:0]    col_q, col_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    row_n_q, row_n_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          latched_low_s;
   logic          hit_s;

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      key_code_d    = CODE_NONE;
      key_valid_d   = 1'b0;
      latched_low_s = col_is_low(cs_q, col_q);
`ifdef KEYPAD_GHOST_REJECT_EN
      hit_s         = (cs_q != 3'b111) && !multi_low(cs_q);
`else
      hit_s         = (cs_q != 3'b111);
`endif

      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = CNT_ZERO;
               if (hit_s) begin
                  col_d   = first_low(cs_q);
                  state_d = ST_DEBOUNCE;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         // A single high cycle aborts the press; the row is rescanned from a fresh dwell.
         ST_DEBOUNCE: begin
            if (!latched_low_s) begin
               state_d = ST_SCAN;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = ST_HELD;
               cnt_d       = CNT_ZERO;
               key_code_d  = decode_key(row_q, col_q);
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HELD: begin
            cnt_d = CNT_ZERO;
            if (!latched_low_s) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_HELD;
            end
         end
         ST_RELEASE: begin
            if (latched_low_s) begin
               state_d = ST_HELD;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_SCAN;
               cnt_d   = CNT_ZERO;
               row_d   = row_q + 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_SCAN;
            cnt_d   = CNT_ZERO;
         end
      endcase

      row_n_d = row_drive(row_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 3'b111;
         cs_q        <= 3'b111;
         state_q     <= ST_SCAN;
         row_q       <= 2'd0;
         col_q       <= 2'd0;
         cnt_q       <= CNT_ZERO;
         row_n_q     <= 4'b1110;
         key_code_q  <= CODE_NONE;
         key_valid_q <= 1'b0;
      end else begin
         sync1_q     <= col_n;
         cs_q        <= sync1_q;
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         row_n_q     <= row_n_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign row_n     = row_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule
